inst_fetcher: RTL and testbench
===============================

Name: inst_fetcher

Overview:
Front-end controller that sequences instruction supply to the decoder. It owns the PC, issues one fetch at a time to the instruction cache, and buffers the returned word. It hands the word to the decoder as pc/opcode/exop when the decoder queries. It applies static next-PC prediction, stalls behind JALR, and flushes on a redirect from the reorder buffer.

Parameters:
ADDR_WIDTH, 32, PC and fetch-address width
RESET_PC, 32'h0, PC loaded at reset
BR_PREDICT, 1, 1 = backward conditional branches predicted taken; 0 = always fall through

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous, active-low reset (sampled on clk_in rising edge)
rdy_in  input  1  global ready; low freezes all state
IF2IC_en  output  1  one-cycle fetch request
IF2IC_addr  output  ADDR_WIDTH  fetch address
IC2IF_en  input  1  cache response valid (one cycle)
IC2IF_inst  input  32  returned instruction word
DC2IF_query_inst  input  1  decoder/dispatcher can accept an instruction this cycle
IF2DC_en  output  1  one-cycle instruction-valid pulse to decoder
IF2DC_pc  output  ADDR_WIDTH  PC of delivered instruction
IF2DC_opcode  output  7  inst[6:0]
IF2DC_exop  output  25  inst[31:7]
RB2IF_jump_en  input  1  redirect (mispredict/JALR resolve)
RB2IF_jump_pc  input  ADDR_WIDTH  redirect target

Behaviour:
- All outputs are registered. Reset (rst_in==0 at posedge): pc=RESET_PC, state=REQ, buffer invalid. IF2IC_en, IF2IC_addr, IF2DC_en, IF2DC_pc, IF2DC_opcode and IF2DC_exop are all 0.
- rdy_in==0: no register changes, outputs held. The cache response must not arrive while frozen. Reset overrides rdy_in.
- States: REQ, WAIT, HOLD, STALL, DROP.
- REQ: drive IF2IC_en=1 and IF2IC_addr=pc for exactly one cycle, then go to WAIT.
- WAIT: on IC2IF_en, latch inst and its pc into the buffer, compute next pc, then go to HOLD. If the opcode is JALR (1100111), go to HOLD with stall flag set.
- Next-PC rules. JAL (1101111): pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}). B-type (1100011) with inst[31]==1 and BR_PREDICT==1: pc + sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}). Otherwise: pc+4. All additions are modulo 2^ADDR_WIDTH and wrap silently.
- HOLD: at the edge with DC2IF_query_inst==1, the next cycle carries IF2DC_en=1 with the buffered fields. Then go to REQ, or to STALL if the stall flag is set. IF2DC_en is 0 in every other cycle. Fields hold their last value when en==0.
- STALL: no fetches. Wait for RB2IF_jump_en.
- Redirect (RB2IF_jump_en==1) has highest priority in every state:
  - pc <= RB2IF_jump_pc, buffer invalid, stall flag cleared, IF2DC_en <= 0.
  - From WAIT without IC2IF_en in the same cycle: go to DROP.
  - Otherwise: go to REQ.
  - A same-cycle IC2IF_en is discarded.
  - A same-cycle query in HOLD delivers nothing.
- DROP: wait for IC2IF_en, discard the word, go to REQ. A further redirect in DROP updates pc and stays in DROP.
- At most one cache request is outstanding. At most one instruction is buffered.
- Minimum latency, REQ to IF2DC_en: 1 (req) + cache latency + 1 (HOLD) + 1.

Test Plan:
- Reset with RESET_PC=0, cache returns 32'h00500093 after 2 cycles, query held high -> IF2IC_addr=0; IF2DC_en pulse with pc=0, opcode=7'h13, exop=inst[31:7]; next request addr=4.
- Query held low 10 cycles in HOLD -> IF2DC_en stays 0, no new IF2IC_en; query high -> single pulse, then request addr=pc+4.
- JAL 32'h0080006F at pc=0x10 -> next IF2IC_addr=0x18. BEQ with offset -8 at pc=0x20 -> next addr=0x18 (BR_PREDICT=1), 0x24 (BR_PREDICT=0).
- JALR at pc=0x30 -> delivered, no further IF2IC_en; RB2IF_jump_en with pc=0x100 -> IF2IC_addr=0x100 next cycle.
- Redirect to 0x200 in WAIT, response arrives 3 cycles later -> word discarded, no IF2DC_en, then request addr=0x200.
- rdy_in low mid-HOLD with query high -> no pulse until rdy_in returns. Reset mid-WAIT -> all outputs 0, request at RESET_PC.

Source files
------------

// File: rtl/inst_fetcher.sv
// Instruction fetch front end: owns the PC, issues one cache fetch at a time,
// buffers the returned word and hands it to the decoder on query.
`timescale 1ns/1ps
module inst_fetcher #(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter bit                    BR_PREDICT = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  output logic                  IF2IC_en,
  output logic [ADDR_WIDTH-1:0] IF2IC_addr,
  input  logic                  IC2IF_en,
  input  logic [31:0]           IC2IF_inst,
  input  logic                  DC2IF_query_inst,
  output logic                  IF2DC_en,
  output logic [ADDR_WIDTH-1:0] IF2DC_pc,
  output logic [6:0]            IF2DC_opcode,
  output logic [24:0]           IF2DC_exop,
  input  logic                  RB2IF_jump_en,
  input  logic [ADDR_WIDTH-1:0] RB2IF_jump_pc
);

  typedef enum logic [2:0] {
    REQ,
    WAIT,
    HOLD,
    STALL,
    DROP
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] buf_pc;
  logic [31:0]           buf_inst;
  logic                  stall_flag;

  logic signed [20:0]    jal_imm;
  logic signed [12:0]    br_imm;
  logic [ADDR_WIDTH-1:0] next_pc;

  // Static prediction on the word arriving from the cache; pc still holds its fetch address.
  always_comb begin
    jal_imm = {IC2IF_inst[31], IC2IF_inst[19:12], IC2IF_inst[20], IC2IF_inst[30:21], 1'b0};
    br_imm  = {IC2IF_inst[31], IC2IF_inst[7], IC2IF_inst[30:25], IC2IF_inst[11:8], 1'b0};
    next_pc = pc + ADDR_WIDTH'(4);
    if (IC2IF_inst[6:0] == OP_JAL) begin
      next_pc = pc + ADDR_WIDTH'(jal_imm);
    end else if (IC2IF_inst[6:0] == OP_BRANCH && IC2IF_inst[31] && BR_PREDICT) begin
      next_pc = pc + ADDR_WIDTH'(br_imm);
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state        <= REQ;
      pc           <= RESET_PC;
      buf_pc       <= '0;
      buf_inst     <= '0;
      stall_flag   <= 1'b0;
      IF2IC_en     <= 1'b0;
      IF2IC_addr   <= '0;
      IF2DC_en     <= 1'b0;
      IF2DC_pc     <= '0;
      IF2DC_opcode <= '0;
      IF2DC_exop   <= '0;
    end else if (rdy_in) begin
      IF2IC_en <= 1'b0;
      IF2DC_en <= 1'b0;
      if (RB2IF_jump_en) begin
        pc         <= RB2IF_jump_pc;
        stall_flag <= 1'b0;
        // A fetch still in flight must be absorbed before the next request can go out.
        if ((state == WAIT || state == DROP) && !IC2IF_en) begin
          state <= DROP;
        end else begin
          state <= REQ;
        end
      end else begin
        unique case (state)
          REQ: begin
            IF2IC_en   <= 1'b1;
            IF2IC_addr <= pc;
            state      <= WAIT;
          end
          WAIT: begin
            if (IC2IF_en) begin
              buf_inst   <= IC2IF_inst;
              buf_pc     <= pc;
              pc         <= next_pc;
              stall_flag <= (IC2IF_inst[6:0] == OP_JALR);
              state      <= HOLD;
            end
          end
          HOLD: begin
            if (DC2IF_query_inst) begin
              IF2DC_en     <= 1'b1;
              IF2DC_pc     <= buf_pc;
              IF2DC_opcode <= buf_inst[6:0];
              IF2DC_exop   <= buf_inst[31:7];
              state        <= stall_flag ? STALL : REQ;
            end
          end
          STALL: begin
            state <= STALL;
          end
          DROP: begin
            if (IC2IF_en) begin
              state <= REQ;
            end
          end
          default: begin
            state <= REQ;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomized scoreboard bench for inst_fetcher: a transaction-level fetch model
// predicts fetch addresses and the delivered instruction stream.
`timescale 1ns/1ps
module tb_inst_fetcher;

  localparam logic [31:0] RPC = 32'h0;
  localparam bit          BRP = 1'b1;
  localparam int          N_CYCLES = 4000;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        IF2IC_en;
  logic [31:0] IF2IC_addr;
  logic        IC2IF_en = 1'b0;
  logic [31:0] IC2IF_inst = '0;
  logic        DC2IF_query_inst = 1'b0;
  logic        IF2DC_en;
  logic [31:0] IF2DC_pc;
  logic [6:0]  IF2DC_opcode;
  logic [24:0] IF2DC_exop;
  logic        RB2IF_jump_en = 1'b0;
  logic [31:0] RB2IF_jump_pc = '0;

  inst_fetcher #(
    .ADDR_WIDTH(32),
    .RESET_PC  (RPC),
    .BR_PREDICT(BRP)
  ) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .rdy_in          (rdy_in),
    .IF2IC_en        (IF2IC_en),
    .IF2IC_addr      (IF2IC_addr),
    .IC2IF_en        (IC2IF_en),
    .IC2IF_inst      (IC2IF_inst),
    .DC2IF_query_inst(DC2IF_query_inst),
    .IF2DC_en        (IF2DC_en),
    .IF2DC_pc        (IF2DC_pc),
    .IF2DC_opcode    (IF2DC_opcode),
    .IF2DC_exop      (IF2DC_exop),
    .RB2IF_jump_en   (RB2IF_jump_en),
    .RB2IF_jump_pc   (RB2IF_jump_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } item_t;

  item_t       exp_q[$];
  int          checks = 0;
  int          failures = 0;
  bit          last_active = 1'b1;
  bit          last_reset = 1'b0;
  bit          outstanding = 1'b0;
  bit          discard_pending = 1'b0;
  bit          stalled = 1'b0;
  logic [31:0] model_pc = RPC;
  logic [31:0] req_addr = '0;
  int          deliveries = 0;
  int          requests = 0;
  bit          done = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural next-fetch rule: JAL target, backward branch target, else sequential.
  function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] inst);
    logic [20:0] j;
    logic [12:0] b;
    int          off;
    j   = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    b   = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    off = 4;
    if (inst[6:0] == 7'b1101111) off = int'(j) - (inst[31] ? (1 << 21) : 0);
    else if (inst[6:0] == 7'b1100011 && inst[31] && BRP) off = int'(b) - 8192;
    return pc + 32'(off);
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] r;
    int          k;
    r = $urandom;
    k = $urandom_range(0, 99);
    if (k < 40) r[6:0] = 7'b0010011;
    else if (k < 55) r[6:0] = 7'b1101111;
    else if (k < 75) r[6:0] = 7'b1100011;
    else if (k < 82) r[6:0] = 7'b1100111;
    return r;
  endfunction

  // Model update at each clock edge from the inputs the DUT samples there.
  always @(posedge clk_in) begin
    if (!rst_in) begin
      last_active     = 1'b1;
      last_reset      = 1'b1;
      exp_q.delete();
      model_pc        = RPC;
      outstanding     = 1'b0;
      discard_pending = 1'b0;
      stalled         = 1'b0;
    end else if (rdy_in) begin
      last_active = 1'b1;
      last_reset  = 1'b0;
      if (RB2IF_jump_en) begin
        model_pc = RB2IF_jump_pc;
        exp_q.delete();
        stalled = 1'b0;
        if (IC2IF_en) begin
          outstanding     = 1'b0;
          discard_pending = 1'b0;
        end else if (outstanding) begin
          discard_pending = 1'b1;
        end
      end else if (IC2IF_en) begin
        outstanding = 1'b0;
        if (discard_pending) begin
          discard_pending = 1'b0;
        end else begin
          exp_q.push_back('{pc: req_addr, inst: IC2IF_inst});
          model_pc = predict(req_addr, IC2IF_inst);
          if (IC2IF_inst[6:0] == 7'b1100111) stalled = 1'b1;
        end
      end
    end else begin
      last_active = 1'b0;
      last_reset  = 1'b0;
    end
  end

  // Monitor: compares deliveries against the scoreboard and checks freeze/reset behaviour.
  initial begin : monitor
    logic [127:0] snap;
    logic [127:0] cur;
    bit           have_snap;
    item_t        it;
    have_snap = 1'b0;
    snap      = '0;
    while (!done) begin
      @(negedge clk_in);
      cur = {IF2IC_en, IF2IC_addr, IF2DC_en, IF2DC_pc, IF2DC_opcode, IF2DC_exop};
      if (last_reset) begin
        chk("reset_outputs", 64'(cur[63:0]) | 64'(cur[127:64]), 64'd0);
      end else if (last_active) begin
        if (IF2DC_en) begin
          if (exp_q.size() == 0) begin
            chk("spurious_delivery", 64'd1, 64'd0);
          end else begin
            it = exp_q.pop_front();
            chk("deliver_pc", 64'(IF2DC_pc), 64'(it.pc));
            chk("deliver_opcode", 64'(IF2DC_opcode), 64'(it.inst[6:0]));
            chk("deliver_exop", 64'(IF2DC_exop), 64'(it.inst[31:7]));
            deliveries++;
          end
        end
      end else if (have_snap) begin
        chk("freeze_hold_lo", cur[63:0], snap[63:0]);
        chk("freeze_hold_hi", cur[127:64], snap[127:64]);
      end
      snap      = cur;
      have_snap = 1'b1;
    end
  end

  // Driver: cache responder, decoder query, redirects, rdy and reset stimulus.
  initial begin : driver
    int lat;
    int idle;
    lat  = 0;
    idle = 0;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk_in);
      if (last_active && rst_in && IF2IC_en) begin
        chk("single_outstanding", 64'(outstanding), 64'd0);
        chk("no_fetch_in_stall", 64'(stalled), 64'd0);
        chk("single_buffer", 64'(exp_q.size()), 64'd0);
        chk("fetch_addr", 64'(IF2IC_addr), 64'(model_pc));
        outstanding = 1'b1;
        req_addr    = IF2IC_addr;
        lat         = $urandom_range(0, 3);
        requests++;
      end
      if (last_active && (IF2IC_en || IF2DC_en || RB2IF_jump_en || !rst_in)) idle = 0;
      else if (last_active) idle++;
      if (idle > 100) begin
        checks++;
        failures++;
        $display("FAIL progress: no fetch or delivery for %0d cycles, required at most 100", idle);
        idle = 0;
      end

      rst_in = !(cyc < 2 || (cyc >= 2000 && cyc < 2002));
      rdy_in = ($urandom_range(0, 9) != 0);
      DC2IF_query_inst = (cyc % 200 < 20) ? 1'b0 : 1'($urandom_range(0, 1));
      IC2IF_en = 1'b0;
      if (outstanding && rdy_in && rst_in) begin
        if (lat == 0) begin
          IC2IF_en   = 1'b1;
          IC2IF_inst = gen_inst();
        end else begin
          lat--;
        end
      end
      RB2IF_jump_en = rdy_in && rst_in && ($urandom_range(0, 99) < (stalled ? 25 : 3));
      RB2IF_jump_pc = 32'($urandom_range(0, 4095)) << 2;
    end
    @(negedge clk_in);
    rdy_in        = 1'b0;
    IC2IF_en      = 1'b0;
    RB2IF_jump_en = 1'b0;
    chk("enough_deliveries", 64'(deliveries > 200), 64'd1);
    chk("enough_requests", 64'(requests > 200), 64'd1);
    done = 1'b1;
    @(negedge clk_in);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
